// File: rtl/sc_reg_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// sc_reg_bus_sequencer_pkg
// Shared constants, state encoding and request-validity helper for the
// register bus sequencer.
// Revision: 1.0
// ============================================================================
package sc_reg_bus_sequencer_pkg;

  localparam int NUM_REGS = 38;
  localparam int ADDR_W   = 6;

  localparam logic [ADDR_W-1:0] READ_ONLY_DST = 6'h3F;
  localparam logic [ADDR_W-1:0] MAX_IDX       = ADDR_W'(NUM_REGS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  // A request is usable when the source names a real register and the
  // destination is either a real register or the read-only marker.
  function automatic logic req_is_valid(input logic [ADDR_W-1:0] src,
                                        input logic [ADDR_W-1:0] dst);
    return (src <= MAX_IDX) && ((dst <= MAX_IDX) || (dst == READ_ONLY_DST));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_reg_bus_sequencer_onehot.sv
`default_nettype none
// ============================================================================
// sc_onehot_decoder
// Register index to one-hot vector; indices beyond the vector give all-zero.
// Revision: 1.0
// ============================================================================
module sc_onehot_decoder #(
  parameter int IDX_W = 6,
  parameter int OUT_W = 38
) (
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] onehot
);

  // One comparator per output bit; out-of-range indices match none.
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign onehot[i] = (idx == IDX_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/sc_reg_bus_sequencer.sv
`default_nettype none
// ============================================================================
// sc_reg_bus_sequencer
// Round-robin sequencer sharing the register-file read mux and load enables
// between the microcode controller (requester 0) and the host port
// (requester 1). Each transfer runs select -> capture -> write-back.
// Revision: 1.0
// ============================================================================
module sc_reg_bus_sequencer
  import sc_reg_bus_sequencer_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_OUT = 38,
  parameter int DATAWIDTH_BUS         = 32,
  parameter int DATAWIDTH_ADDR        = 6
) (
  input  logic                             SC_BUSSEQ_CLOCK_50,
  input  logic                             SC_BUSSEQ_RESET_InLow,
  input  logic                             SC_BUSSEQ_REQ0_VALID,
  input  logic [DATAWIDTH_ADDR-1:0]        SC_BUSSEQ_REQ0_SRC,
  input  logic [DATAWIDTH_ADDR-1:0]        SC_BUSSEQ_REQ0_DST,
  output logic                             SC_BUSSEQ_REQ0_READY,
  input  logic                             SC_BUSSEQ_REQ1_VALID,
  input  logic [DATAWIDTH_ADDR-1:0]        SC_BUSSEQ_REQ1_SRC,
  input  logic [DATAWIDTH_ADDR-1:0]        SC_BUSSEQ_REQ1_DST,
  output logic                             SC_BUSSEQ_REQ1_READY,
  output logic [DATAWIDTH_DECODER_OUT-1:0] SC_BUSSEQ_MUX_SELECT,
  input  logic [DATAWIDTH_BUS-1:0]         SC_BUSSEQ_BUS_IN,
  output logic [DATAWIDTH_DECODER_OUT-1:0] SC_BUSSEQ_LOAD,
  output logic [DATAWIDTH_BUS-1:0]         SC_BUSSEQ_BUS_OUT,
  output logic                             SC_BUSSEQ_DONE,
  output logic                             SC_BUSSEQ_DONE_ID,
  output logic [DATAWIDTH_BUS-1:0]         SC_BUSSEQ_RDATA,
  output logic                             SC_BUSSEQ_ERR
);

  logic                             clk;
  logic                             rst_n;
  logic [1:0]                       state;
  logic                             last;
  logic [DATAWIDTH_ADDR-1:0]        src_q;
  logic [DATAWIDTH_ADDR-1:0]        dst_q;
  logic [DATAWIDTH_BUS-1:0]         rdata_q;
  logic                             err_q;
  logic                             done_id_q;
  logic                             grant;
  logic                             idle;
  logic                             accept;
  logic                             req_ok;
  logic [DATAWIDTH_ADDR-1:0]        gnt_src;
  logic [DATAWIDTH_ADDR-1:0]        gnt_dst;
  logic [DATAWIDTH_DECODER_OUT-1:0] sel_vec;
  logic [DATAWIDTH_DECODER_OUT-1:0] load_vec;

  assign clk   = SC_BUSSEQ_CLOCK_50;
  assign rst_n = SC_BUSSEQ_RESET_InLow;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (SC_BUSSEQ_REQ0_VALID && SC_BUSSEQ_REQ1_VALID) begin
      grant = ~last;
    end else begin
      grant = SC_BUSSEQ_REQ1_VALID;
    end
  end

  assign idle    = (state == ST_IDLE);
  assign accept  = idle && (SC_BUSSEQ_REQ0_VALID || SC_BUSSEQ_REQ1_VALID);
  assign gnt_src = grant ? SC_BUSSEQ_REQ1_SRC : SC_BUSSEQ_REQ0_SRC;
  assign gnt_dst = grant ? SC_BUSSEQ_REQ1_DST : SC_BUSSEQ_REQ0_DST;
  assign req_ok  = req_is_valid(gnt_src, gnt_dst);

  assign SC_BUSSEQ_REQ0_READY = idle && !grant;
  assign SC_BUSSEQ_REQ1_READY = idle && grant;

  // Transfer sequencing; rejected requests never leave IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept && req_ok) state <= ST_SEL;
        ST_SEL:  state <= ST_CAPT;
        ST_CAPT: state <= ST_WB;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Acceptance bookkeeping: arbitration history, owner id, error pulse, latched indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        last      <= grant;
        done_id_q <= grant;
        err_q     <= !req_ok;
        if (req_ok) begin
          src_q <= gnt_src;
          dst_q <= gnt_dst;
        end
      end
    end
  end

  // Capture the mux output at the end of CAPT; it doubles as the write-back value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state == ST_CAPT) begin
      rdata_q <= SC_BUSSEQ_BUS_IN;
    end
  end

  sc_onehot_decoder #(.IDX_W(DATAWIDTH_ADDR), .OUT_W(DATAWIDTH_DECODER_OUT)) u_sel_dec (
    .idx    (src_q),
    .onehot (sel_vec)
  );

  // The read-only marker is out of range, so it decodes to no load at all.
  sc_onehot_decoder #(.IDX_W(DATAWIDTH_ADDR), .OUT_W(DATAWIDTH_DECODER_OUT)) u_load_dec (
    .idx    (dst_q),
    .onehot (load_vec)
  );

  assign SC_BUSSEQ_MUX_SELECT = ((state == ST_SEL) || (state == ST_CAPT)) ? sel_vec : '0;
  assign SC_BUSSEQ_LOAD       = (state == ST_WB) ? load_vec : '0;
  assign SC_BUSSEQ_BUS_OUT    = (state == ST_WB) ? rdata_q : '0;
  assign SC_BUSSEQ_DONE       = (state == ST_WB);
  assign SC_BUSSEQ_DONE_ID    = done_id_q;
  assign SC_BUSSEQ_RDATA      = rdata_q;
  assign SC_BUSSEQ_ERR        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_reg_bus_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sc_reg_bus_sequencer
// Self-checking bench: transaction-timeline reference model plus directed
// literal checks and a randomized phase.
// Revision: 1.0
// ============================================================================
module tb_sc_reg_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [5:0]  src0 = '0, dst0 = '0, src1 = '0, dst1 = '0;
  logic        rdy0, rdy1;
  logic [37:0] mux_sel, load;
  logic [31:0] bus_in = '0, bus_out, rdata;
  logic        done, done_id, err;

  int total = 0;
  int bad   = 0;

  sc_reg_bus_sequencer dut (
    .SC_BUSSEQ_CLOCK_50    (clk),
    .SC_BUSSEQ_RESET_InLow (rst_n),
    .SC_BUSSEQ_REQ0_VALID  (v0),
    .SC_BUSSEQ_REQ0_SRC    (src0),
    .SC_BUSSEQ_REQ0_DST    (dst0),
    .SC_BUSSEQ_REQ0_READY  (rdy0),
    .SC_BUSSEQ_REQ1_VALID  (v1),
    .SC_BUSSEQ_REQ1_SRC    (src1),
    .SC_BUSSEQ_REQ1_DST    (dst1),
    .SC_BUSSEQ_REQ1_READY  (rdy1),
    .SC_BUSSEQ_MUX_SELECT  (mux_sel),
    .SC_BUSSEQ_BUS_IN      (bus_in),
    .SC_BUSSEQ_LOAD        (load),
    .SC_BUSSEQ_BUS_OUT     (bus_out),
    .SC_BUSSEQ_DONE        (done),
    .SC_BUSSEQ_DONE_ID     (done_id),
    .SC_BUSSEQ_RDATA       (rdata),
    .SC_BUSSEQ_ERR         (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction timeline) ----------------
  // A valid transfer accepted at the edge ending cycle k occupies cycles
  // s=k+1 (select), s+1 (capture), s+2 (write-back).
  int         cyc     = 0;
  bit         tx_live = 1'b0;
  int         s       = -100;
  int         err_cyc = -100;
  int         tx_src  = 0;
  int         tx_dst  = 0;
  bit         m_last  = 1'b1;
  bit         m_id    = 1'b0;
  logic [31:0] m_rdata = '0;

  function automatic logic [37:0] oh(input int i);
    logic [37:0] one;
    one = 38'd1;
    if (i >= 0 && i < 38) return one << i;
    return '0;
  endfunction

  function automatic bit busy_in(input int c);
    return tx_live && (c >= s) && (c <= s + 2);
  endfunction

  // Whoever is alone wins; on a tie the one not served most recently wins.
  function automatic bit pick(input bit a, input bit b, input bit lst);
    if (a && b) return (lst == 1'b0) ? 1'b1 : 1'b0;
    return b;
  endfunction

  always @(posedge clk) begin
    int sv, dv;
    bit g;
    if (!rst_n) begin
      tx_live = 1'b0; s = -100; err_cyc = -100;
      m_last = 1'b1; m_id = 1'b0; m_rdata = '0;
    end else begin
      if (tx_live && cyc == s + 1) m_rdata = bus_in;
      if (!busy_in(cyc) && (v0 || v1)) begin
        g  = pick(v0, v1, m_last);
        sv = g ? int'(src1) : int'(src0);
        dv = g ? int'(dst1) : int'(dst0);
        m_last = g;
        m_id   = g;
        if (sv <= 37 && (dv <= 37 || dv == 63)) begin
          tx_live = 1'b1; s = cyc + 1; tx_src = sv; tx_dst = dv;
        end else begin
          err_cyc = cyc + 1;
        end
      end
    end
    cyc++;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int  c;
    bit  wb, g;
    c  = cyc;
    wb = tx_live && (c == s + 2);
    g  = pick(v0, v1, m_last);
    chk("mux_select", 64'(mux_sel), (tx_live && (c == s || c == s + 1)) ? 64'(oh(tx_src)) : 64'd0);
    chk("load", 64'(load), (wb && tx_dst != 63) ? 64'(oh(tx_dst)) : 64'd0);
    chk("bus_out", 64'(bus_out), wb ? 64'(m_rdata) : 64'd0);
    chk("done", 64'(done), 64'(wb));
    chk("err", 64'(err), 64'(c == err_cyc));
    chk("done_id", 64'(done_id), 64'(m_id));
    chk("rdata", 64'(rdata), 64'(m_rdata));
    chk("ready0", 64'(rdy0), 64'(!busy_in(c) && g == 1'b0));
    chk("ready1", 64'(rdy1), 64'(!busy_in(c) && g == 1'b1));
    chk("mux_onehot0", 64'($onehot0(mux_sel)), 64'd1);
    chk("load_onehot0", 64'($onehot0(load)), 64'd1);
  endtask

  task automatic neg();
    @(negedge clk);
    if (rst_n) compare_all();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      neg();
      pos();
    end
  endtask

  task automatic clear_reqs();
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    pos();
    pos();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Reset state
    neg();
    chk("rst_mux", 64'(mux_sel), 64'd0);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_bus_out", 64'(bus_out), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_done_id", 64'(done_id), 64'd0);
    pos();

    // Single transfer 5 -> 12
    v0 = 1'b1; src0 = 6'd5; dst0 = 6'd12; bus_in = 32'hDEADBEEF;
    neg(); chk("a_ready0", 64'(rdy0), 64'd1); pos();
    v0 = 1'b0;
    neg(); chk("a_sel_c1", 64'(mux_sel), 64'(oh(5))); pos();
    neg(); chk("a_sel_c2", 64'(mux_sel), 64'(oh(5))); pos();
    neg();
    chk("a_load", 64'(load), 64'(oh(12)));
    chk("a_bus_out", 64'(bus_out), 64'hDEADBEEF);
    chk("a_done", 64'(done), 64'd1);
    chk("a_done_id", 64'(done_id), 64'd0);
    pos();
    neg(); chk("a_rdata", 64'(rdata), 64'hDEADBEEF); chk("a_done_low", 64'(done), 64'd0); pos();

    // Contention from reset: requester 0 first, requester 1 accepted in cycle 4
    do_reset();
    v0 = 1'b1; src0 = 6'd1; dst0 = 6'd2;
    v1 = 1'b1; src1 = 6'd3; dst1 = 6'd4; bus_in = 32'h0000_1111;
    neg(); chk("b_ready0", 64'(rdy0), 64'd1); chk("b_ready1", 64'(rdy1), 64'd0); pos();
    v0 = 1'b0;
    idle_cycles(2);
    neg(); chk("b_done0", 64'(done), 64'd1); chk("b_load0", 64'(load), 64'(oh(2))); pos();
    neg(); chk("b_ready1_c4", 64'(rdy1), 64'd1); pos();
    v1 = 1'b0; bus_in = 32'h0000_2222;
    idle_cycles(2);
    neg();
    chk("b_done1", 64'(done), 64'd1);
    chk("b_done1_id", 64'(done_id), 64'd1);
    chk("b_load1", 64'(load), 64'(oh(4)));
    pos();

    // Read-only from the top register
    v1 = 1'b1; src1 = 6'd37; dst1 = 6'h3F; bus_in = 32'h1234_5678;
    neg(); pos();
    v1 = 1'b0;
    neg(); chk("c_sel1", 64'(mux_sel), 64'(oh(37))); pos();
    neg(); chk("c_sel2", 64'(mux_sel), 64'(oh(37))); pos();
    neg();
    chk("c_load", 64'(load), 64'd0);
    chk("c_done", 64'(done), 64'd1);
    chk("c_done_id", 64'(done_id), 64'd1);
    pos();
    neg(); chk("c_rdata", 64'(rdata), 64'h1234_5678); pos();

    // Rejected requests: bad source, then bad destination
    v0 = 1'b1; src0 = 6'd40; dst0 = 6'd2;
    neg(); chk("d_ready", 64'(rdy0), 64'd1); pos();
    src0 = 6'd1; dst0 = 6'd38;
    neg(); chk("d_err1", 64'(err), 64'd1); chk("d_err1_mux", 64'(mux_sel), 64'd0); pos();
    v0 = 1'b0;
    neg(); chk("d_err2", 64'(err), 64'd1); chk("d_err2_id", 64'(done_id), 64'd0); pos();
    idle_cycles(2);

    // Reset during capture
    v0 = 1'b1; src0 = 6'd7; dst0 = 6'd9; bus_in = 32'hCAFE_F00D;
    neg(); pos();
    v0 = 1'b0;
    neg(); pos();
    chk("e_capt_mux", 64'(mux_sel), 64'(oh(7)));
    rst_n = 1'b0;
    #1;
    chk("e_rst_mux", 64'(mux_sel), 64'd0);
    chk("e_rst_load", 64'(load), 64'd0);
    chk("e_rst_done", 64'(done), 64'd0);
    chk("e_rst_rdata", 64'(rdata), 64'd0);
    pos();
    pos();
    rst_n = 1'b1;
    idle_cycles(3);
    v0 = 1'b1; src0 = 6'd7; dst0 = 6'd9; bus_in = 32'h0BAD_CAFE;
    neg(); pos();
    v0 = 1'b0;
    idle_cycles(2);
    neg(); chk("e_after_load", 64'(load), 64'(oh(9))); chk("e_after_bus", 64'(bus_out), 64'h0BAD_CAFE); pos();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      int r;
      v0 = ($urandom % 3) != 0;
      v1 = ($urandom % 3) != 0;
      src0 = 6'($urandom_range(0, 41));
      src1 = 6'($urandom_range(0, 41));
      r = int'($urandom % 8);
      dst0 = (r == 0) ? 6'h3F : (r == 1) ? 6'($urandom_range(38, 62)) : 6'($urandom_range(0, 37));
      r = int'($urandom % 8);
      dst1 = (r == 0) ? 6'h3F : (r == 1) ? 6'($urandom_range(38, 62)) : 6'($urandom_range(0, 37));
      bus_in = $urandom;
      if (($urandom % 400) == 0) begin
        rst_n = 1'b0;
        pos();
        rst_n = 1'b1;
      end else begin
        neg();
        pos();
      end
    end

    clear_reqs();
    idle_cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc_reg_bus_sequencer.md
# sc_reg_bus_sequencer

Controller that shares the 38-register file read mux and register load enables between two requesters: the microcode datapath controller (requester 0) and the host debug/loader port (requester 1). Each accepted request moves one register value to another register, or reads it back only. The block converts 6-bit register indices into the one-hot mux select and one-hot load vectors, sequences select → capture → write-back, and arbitrates round-robin.

## Interface
- DATAWIDTH_DECODER_OUT, 38, number of registers / one-hot select width
- DATAWIDTH_BUS, 32, register/bus data width
- DATAWIDTH_ADDR, 6, register index width
- SC_BUSSEQ_CLOCK_50  in  1  single clock; all state changes on rising edge
- SC_BUSSEQ_RESET_InLow  in  1  asynchronous, active-low reset
- SC_BUSSEQ_REQ0_VALID  in  1  requester 0 request valid
- SC_BUSSEQ_REQ0_SRC  in  6  requester 0 source register index
- SC_BUSSEQ_REQ0_DST  in  6  requester 0 destination index; 6'h3F = read-only
- SC_BUSSEQ_REQ0_READY  out  1  requester 0 accepted this cycle when VALID&READY
- SC_BUSSEQ_REQ1_VALID / _SRC / _DST / _READY  same as requester 0, for requester 1
- SC_BUSSEQ_MUX_SELECT  out  38  one-hot read-mux select; all-zero when idle
- SC_BUSSEQ_BUS_IN  in  32  read-mux output
- SC_BUSSEQ_LOAD  out  38  one-hot register load enables
- SC_BUSSEQ_BUS_OUT  out  32  write-back data to register inputs
- SC_BUSSEQ_DONE  out  1  one-cycle completion pulse
- SC_BUSSEQ_DONE_ID  out  1  requester that owns the DONE/ERR pulse
- SC_BUSSEQ_RDATA  out  32  captured source value, held until next capture
- SC_BUSSEQ_ERR  out  1  one-cycle pulse: rejected request (bad index)

## Operation
- States: IDLE, SEL, CAPT, WB.
- READYn = (state==IDLE) && (grant==n); grant combinational from VALIDs and LAST pointer.
- Arbitration: single valid requester wins; both valid → requester ≠ LAST wins. LAST updates on every acceptance (including error acceptances). Reset LAST=1 so requester 0 wins the first tie.
- Validity: SRC ≤ 37 required; DST ≤ 37 or DST == 6'h3F. Otherwise the request is consumed, no bus activity, ERR=1 and DONE_ID=n in the next cycle, state stays IDLE.
- Valid acceptance: latch SRC/DST/ID, IDLE→SEL. MUX_SELECT = onehot(SRC) during SEL and CAPT.
- SEL→CAPT unconditionally (one settling cycle for the mux path).
- End of CAPT: hold ← BUS_IN, RDATA ← BUS_IN, CAPT→WB.
- WB: LOAD = onehot(DST) (all-zero if read-only), BUS_OUT = hold, DONE=1, DONE_ID=ID, MUX_SELECT=0; WB→IDLE.
- SRC==DST is legal: value rewritten unchanged.
- VALID dropped while not READY: no effect; requests are not queued inside the block.

## Timing
- Reset (asynchronous, immediate): state=IDLE, MUX_SELECT=0, LOAD=0, BUS_OUT=0, RDATA=0, DONE=0, ERR=0, DONE_ID=0, LAST=1. Reset mid-transfer aborts it with no LOAD pulse.
- Acceptance at edge E0 → SEL in cycle 1, CAPT in cycle 2 (BUS_IN sampled at E2), WB/DONE/LOAD in cycle 3, IDLE in cycle 4.
- Throughput: one transfer per 4 cycles. Back-to-back transfers alternate under contention.
- ERR pulse in the cycle after acceptance. A new request is acceptable in that same cycle.
- LOAD and DONE are exactly one cycle wide. Never more than one LOAD bit is set.

## Structure
- Shared package:
  - NUM_REGS=38
  - ADDR_W=6
  - READ_ONLY_DST=6'h3F
  - state encoding IDLE/SEL/CAPT/WB
- Sub-module sc_onehot_decoder:
  - 6-bit index → 38-bit one-hot, all-zero for index ≥ 38
  - instantiated twice (select and load)
- Outputs MUX_SELECT, LOAD, BUS_OUT and DONE are driven from registers or directly from state. No combinational path from BUS_IN to any output.

## Test plan
- Reset, then REQ0 SRC=5 DST=12, BUS_IN=32'hDEADBEEF while MUX_SELECT=1<<5 → LOAD=1<<12, BUS_OUT=32'hDEADBEEF, DONE=1, DONE_ID=0 in cycle 3; RDATA=32'hDEADBEEF afterwards.
- Both requesters valid from reset (REQ0 SRC=1 DST=2, REQ1 SRC=3 DST=4) → REQ0 served first. REQ1 accepted in cycle 4, its DONE in cycle 7.
- REQ1 SRC=37 DST=6'h3F → MUX_SELECT=1<<37 for 2 cycles, LOAD stays 0, DONE=1, DONE_ID=1, RDATA=mux value.
- REQ0 SRC=40 DST=2 → READY for one cycle, ERR=1 next cycle, MUX_SELECT and LOAD stay 0. REQ0 DST=38 (not 3F) → ERR likewise.
- Assert reset during CAPT of SRC=7 DST=9 → all outputs 0 immediately, no LOAD pulse, first request after release accepted normally.
- Monitor throughout: LOAD and MUX_SELECT are always zero or one-hot, and DONE count equals count of valid acceptances.
